dcache_wt_ctrl: RTL

- Parametrised direct-mapped, write-through, no-write-allocate data cache with its own miss/refill state machine.
- Sits between the core's load/store stage and main data memory, replacing the fixed 4-word cache + memory + read-mux arrangement.
- Generalises set count and line length. Refills whole lines over a req/ack memory handshake.
- Stalls the core until each access is resolved.

---
 rtl/dcache_wt_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_wt_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_wt_ctrl
// Direct-mapped, write-through, no-write-allocate data cache with its own
// miss/refill controller. It sits between the core load/store stage and main
// data memory. The core is stalled until each access is resolved.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   i_cpu_addr        : byte address of the access
//   i_cpu_wdata       : store data (byte stores use bits [7:0])
//   i_cpu_byte        : 1 = byte access, 0 = word access
//   i_cpu_re/i_cpu_we : load / store request (store wins if both are high)
//   o_cpu_rdata       : load data; zero unless a load hit is presented
//   o_cpu_stall       : core must hold its request while high
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata/o_mem_wstrb : memory request
//   i_mem_ack/i_mem_rdata : memory completion and read data
// -----------------------------------------------------------------------------
module dcache_wt_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SETS           = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    input  logic                  i_cpu_byte,
    input  logic                  i_cpu_re,
    input  logic                  i_cpu_we,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_cpu_stall,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_wstrb,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int SB = $clog2(SETS);
    localparam int TW = ADDR_WIDTH - 2 - WB - SB;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                r_state;
    logic [WB-1:0]         r_cnt;
    logic                  r_wr_done;   // store was acked last cycle; release the core
    logic [SETS-1:0]       r_valid;
    logic [TW-1:0]         r_tag  [SETS];
    logic [DATA_WIDTH-1:0] r_data [SETS*WORDS_PER_LINE];

    logic [1:0]            w_off;
    logic [WB-1:0]         w_word;
    logic [SB-1:0]         w_set;
    logic [TW-1:0]         w_tag;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_line_word;
    logic [7:0]            w_byte_sel;
    logic [3:0]            w_wstrb;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_off       = i_cpu_addr[1:0];
    assign w_word      = i_cpu_addr[2 +: WB];
    assign w_set       = i_cpu_addr[2+WB +: SB];
    assign w_tag       = i_cpu_addr[ADDR_WIDTH-1 -: TW];
    assign w_hit       = r_valid[w_set] && (r_tag[w_set] == w_tag);
    assign w_line_word = r_data[{w_set, w_word}];
    assign w_byte_sel  = w_line_word[8*w_off +: 8];
    assign w_wstrb     = i_cpu_byte ? (4'b0001 << w_off) : 4'b1111;
    assign w_wdata     = i_cpu_byte ? {4{i_cpu_wdata[7:0]}} : i_cpu_wdata;

    // Store-hit merge: only the enabled lanes replace cached bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign w_merged[gi*8 +: 8] = w_wstrb[gi] ? w_wdata[gi*8 +: 8]
                                                     : w_line_word[gi*8 +: 8];
        end
    endgenerate

    // Control state, counter and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wr_done <= 1'b0;
            r_valid   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wr_done <= 1'b0;
                    if (i_cpu_we) begin
                        if (!r_wr_done)
                            r_state <= WRITE;
                    end else if (i_cpu_re && !w_hit) begin
                        // Invalidate first so a partially refilled line never hits.
                        r_valid[w_set] <= 1'b0;
                        r_cnt          <= '0;
                        r_state        <= REFILL;
                    end
                end
                REFILL: begin
                    if (i_mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == WB'(WORDS_PER_LINE-1)) begin
                            r_valid[w_set] <= 1'b1;
                            r_state        <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (i_mem_ack) begin
                        r_wr_done <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag and data storage are never cleared; writes are suppressed during reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == REFILL && i_mem_ack) begin
                r_data[{w_set, r_cnt}] <= i_mem_rdata;
                if (r_cnt == WB'(WORDS_PER_LINE-1))
                    r_tag[w_set] <= w_tag;
            end else if (r_state == WRITE && i_mem_ack && w_hit) begin
                r_data[{w_set, w_word}] <= w_merged;
            end
        end
    end

    // Outputs are decoded from state and the held request so a load hit
    // answers in the same cycle; reset forces them all low at once.
    always_comb begin
        o_cpu_rdata = '0;
        o_cpu_stall = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wstrb = 4'b0000;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (i_cpu_we) begin
                        o_cpu_stall = !r_wr_done;
                    end else if (i_cpu_re) begin
                        if (w_hit)
                            o_cpu_rdata = i_cpu_byte ? {{(DATA_WIDTH-8){1'b0}}, w_byte_sel}
                                                     : w_line_word;
                        else
                            o_cpu_stall = 1'b1;
                    end
                end
                REFILL: begin
                    o_cpu_stall = 1'b1;
                    o_mem_req   = 1'b1;
                    o_mem_addr  = {w_tag, w_set, r_cnt, 2'b00};
                end
                WRITE: begin
                    o_cpu_stall = 1'b1;
                    o_mem_req   = 1'b1;
                    o_mem_we    = 1'b1;
                    o_mem_addr  = {i_cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                    o_mem_wdata = w_wdata;
                    o_mem_wstrb = w_wstrb;
                end
                default: ;
            endcase
        end
    end

endmodule
